add_mul_arbiter: RTL and testbench

Shares one add/multiply datapath (4-bit operands, 8-bit result; op 0 = add, op 1 = multiply) between two requesters, using round-robin arbitration and valid/ready handshakes. The block latches the granted request's operands and sequences the arithmetic. Add takes one execute cycle. Multiply is iterative shift-add over four execute cycles. The result is returned, tagged with the requester id, through a held response port. It sits between the operand-producing front ends and the downstream result consumer.

---
 rtl/add_mul_arbiter.sv | 88 ++++++++
 tb/tb_add_mul_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/add_mul_arbiter.sv
// add_mul_arbiter: round-robin shared 4-bit add/multiply unit with valid/ready request and held response ports
// Ports: clk_i, reset_i (sync, active-high)
//   req0/req1: valid_i, op_i (0 add, 1 mul), a_i[3:0], b_i[3:0] in; ready_o out (combinational grant)
//   rsp: valid_o, data_o[7:0], id_o out (registered), ready_i in; busy_o out (registered, not IDLE)
// Build option: ADDMUL_FAST_MUL_EN selects a single-cycle combinational multiply instead of 4-cycle shift-add
module add_mul_arbiter (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req0_valid_i,
  input  logic       req0_op_i,
  input  logic [3:0] req0_a_i,
  input  logic [3:0] req0_b_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic       req1_op_i,
  input  logic [3:0] req1_a_i,
  input  logic [3:0] req1_b_i,
  output logic       req1_ready_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_id_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic last, accept, gnt, done, op, id;
  logic [3:0] a, b;
  logic [7:0] res;
`ifndef ADDMUL_FAST_MUL_EN
  logic [7:0] acc;
  logic [1:0] cnt;
`endif
  assign accept = req0_ready_o | req1_ready_o;
  assign gnt = req1_ready_o;
`ifdef ADDMUL_FAST_MUL_EN
  assign done = 1'b1;
  assign res = op ? {4'b0, a} * {4'b0, b} : {3'b0, {1'b0, a} + {1'b0, b}};
`else
  // res doubles as the next partial product while multiplying
  assign done = !op || cnt == 2'd3;
  assign res = op ? acc + (b[cnt] ? {4'b0, a} << cnt : 8'd0) : {3'b0, {1'b0, a} + {1'b0, b}};
`endif
  always_ff @(posedge clk_i)
    state <= reset_i ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (accept ? EXEC : IDLE) :
              state == EXEC ? (done ? RESP : EXEC) :
              (rsp_ready_i ? IDLE : RESP);
  // the requester that did not win last time takes a tie
  always_comb begin
    req0_ready_o = !reset_i && state == IDLE && req0_valid_i && (!req1_valid_i || last);
    req1_ready_o = !reset_i && state == IDLE && req1_valid_i && (!req0_valid_i || !last);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o <= 8'd0;
      rsp_id_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      busy_o <= state_n != IDLE;
      rsp_valid_o <= state_n == RESP;
      if (accept) begin
        op <= gnt ? req1_op_i : req0_op_i;
        a <= gnt ? req1_a_i : req0_a_i;
        b <= gnt ? req1_b_i : req0_b_i;
        id <= gnt;
        last <= gnt;
`ifndef ADDMUL_FAST_MUL_EN
        acc <= 8'd0;
        cnt <= 2'd0;
`endif
      end
      if (state == EXEC) begin
`ifndef ADDMUL_FAST_MUL_EN
        acc <= res;
        cnt <= cnt + 2'd1;
`endif
        if (done) begin
          rsp_data_o <= res;
          rsp_id_o <= id;
        end
      end
    end
  end
endmodule

// File: tb/tb_add_mul_arbiter.sv
// tb_add_mul_arbiter: directed and random checks of add_mul_arbiter against a transaction-level model
module tb_add_mul_arbiter;
`ifdef ADDMUL_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 4;
`endif
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, v0, op0, r0, v1, op1, r1, rv, rr, rid, busy;
  logic [3:0] a0, b0, a1, b1;
  logic [7:0] rdata;
  add_mul_arbiter dut (
    .clk_i(clk), .reset_i(rst),
    .req0_valid_i(v0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(r1),
    .rsp_valid_o(rv), .rsp_ready_i(rr), .rsp_data_o(rdata), .rsp_id_o(rid), .busy_o(busy)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  int m_st = 0, m_left = 0;
  bit m_last = 1, m_pid = 0, m_id = 0, m_valid = 0, m_busy = 0, acc0 = 0, acc1 = 0;
  int m_res = 0, m_data = 0;
  int glog[$], rlog[$], ilog[$];
  task automatic cycle();
    bit e0, e1;
    #2;
    e0 = !rst && m_st == 0 && v0 && (!v1 || m_last);
    e1 = !rst && m_st == 0 && v1 && (!v0 || !m_last);
    chk("ready0", r0, e0);
    chk("ready1", r1, e1);
    chk("rsp_valid", rv, m_valid);
    chk("rsp_data", rdata, m_data);
    chk("rsp_id", rid, m_id);
    chk("busy", busy, m_busy);
    acc0 = e0;
    acc1 = e1;
    if (rst) begin
      m_st = 0; m_last = 1; m_valid = 0; m_data = 0; m_id = 0; m_busy = 0;
    end else if (m_st == 0) begin
      if (e0 || e1) begin
        m_last = e1;
        m_pid = e1;
        glog.push_back(int'(e1));
        if (e1) m_res = op1 ? int'(a1) * int'(b1) : int'(a1) + int'(b1);
        else m_res = op0 ? int'(a0) * int'(b0) : int'(a0) + int'(b0);
        m_left = (e1 ? op1 : op0) ? MUL_LAT : 1;
        m_st = 1;
        m_busy = 1;
      end
    end else if (m_st == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_st = 2; m_valid = 1; m_data = m_res; m_id = m_pid;
      end
    end else if (rr) begin
      rlog.push_back(m_data);
      ilog.push_back(int'(m_id));
      m_st = 0; m_valid = 0; m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    rst = 1; v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rr = 1;
    #1;
    chk("rst_ready0", r0, 0);
    run(2);
    rst = 0;
    run(1);
    chk("post_rst_valid", rv, 0);
    chk("post_rst_busy", busy, 0);
    v0 = 1; op0 = 0; a0 = 5; b0 = 3;
    #1;
    chk("t1_ready0", r0, 1);
    cycle();
    v0 = 0;
    cycle();
    #1;
    chk("t1_valid", rv, 1);
    chk("t1_data", rdata, 8);
    chk("t1_id", rid, 0);
    run(2);
    v1 = 1; op1 = 1; a1 = 4; b1 = 7;
    cycle();
    v1 = 0;
    run(MUL_LAT);
    #1;
    chk("t2_valid", rv, 1);
    chk("t2_data", rdata, 28);
    chk("t2_id", rid, 1);
    run(2);
    glog.delete(); rlog.delete(); ilog.delete();
    v0 = 1; op0 = 0; a0 = 1; b0 = 1;
    v1 = 1; op1 = 0; a1 = 2; b1 = 2;
    run(12);
    v0 = 0; v1 = 0;
    run(4);
    chk("t3_grants", glog.size() >= 4, 1);
    chk("t3_rsps", rlog.size() >= 4, 1);
    for (int i = 0; i < 4 && i < glog.size() && i < rlog.size(); i++) begin
      chk("t3_grant", glog[i], i % 2);
      chk("t3_data", rlog[i], (i % 2) ? 4 : 2);
      chk("t3_id", ilog[i], i % 2);
    end
    v0 = 1; op0 = 1; a0 = 15; b0 = 15; rr = 0;
    cycle();
    v0 = 0; v1 = 1; op1 = 0; a1 = 1; b1 = 1;
    run(MUL_LAT);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_valid", rv, 1);
      chk("t4_data", rdata, 225);
      chk("t4_ready1", r1, 0);
      cycle();
    end
    rr = 1;
    cycle();
    #1;
    chk("t4_ready1_after", r1, 1);
    cycle();
    v1 = 0;
    run(4);
    rlog.delete();
    v0 = 1; op0 = 1; a0 = 9; b0 = 13;
    cycle();
    v0 = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", rv, 0);
    v0 = 1; op0 = 0; a0 = 3; b0 = 4;
    v1 = 1; op1 = 0; a1 = 6; b1 = 6;
    #1;
    chk("t5_ready0", r0, 1);
    chk("t5_ready1", r1, 0);
    cycle();
    chk("t5_no_rsp", rlog.size(), 0);
    v0 = 0; v1 = 0;
    run(4);
    for (int n = 0; n < 600; n++) begin
      if (!v0 || acc0) begin
        v0 = $urandom_range(0, 1); op0 = $urandom_range(0, 1); a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
      end
      if (!v1 || acc1) begin
        v1 = $urandom_range(0, 1); op1 = $urandom_range(0, 1); a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
      end
      rr = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 63) == 0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
